// File: rtl/alu_4bit_issue.sv
// -----------------------------------------------------------------------------
// alu_4bit_issue
// Request-buffering issue stage that sits in front of the combinational
// alu_4bit. Requests (A, B, opcode) enter through a valid/ready handshake and
// wait in a small FIFO. The head entry drives the ALU. The ALU result, the
// head's opcode and a 3-bit sequence tag are captured in an output register,
// which is presented downstream through a second valid/ready handshake that
// supports full backpressure.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   in_valid    : request present
//   in_ready    : FIFO can accept a request (count < DEPTH)
//   in_a, in_b  : 4-bit signed operands
//   in_op       : 3-bit ALU opcode
//   alu_a/b/op  : head entry, forced to 0 when the FIFO is empty
//   alu_en      : high only in an issue cycle
//   alu_result  : 8-bit result returned by the ALU
//   out_valid   : output register holds a result
//   out_ready   : consumer accepts the result
//   out_result  : captured ALU result
//   out_op      : opcode of the captured result
//   out_tag     : sequence tag of the captured result
//   count       : number of FIFO entries
// -----------------------------------------------------------------------------
module alu_4bit_issue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic [2:0]                 in_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_op,
  output logic                       alu_en,
  input  logic [7:0]                 alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_result,
  output logic [2:0]                 out_op,
  output logic [2:0]                 out_tag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LP_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);

  // FIFO storage; holds data only, so it carries no reset.
  logic [3:0]    r_mem_a   [DEPTH];
  logic [3:0]    r_mem_b   [DEPTH];
  logic [2:0]    r_mem_op  [DEPTH];
  logic [2:0]    r_mem_tag [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [2:0]    r_tag_cnt;

  logic          r_out_valid;
  logic [7:0]    r_out_result;
  logic [2:0]    r_out_op;
  logic [2:0]    r_out_tag;

  logic          w_empty;
  logic          w_in_ready;
  logic          w_push;
  logic          w_issue;

  assign w_empty    = (r_count == '0);
  // No full-bypass: a pop in the same cycle does not open the input.
  assign w_in_ready = (r_count < LP_FULL);
  assign w_push     = in_valid && w_in_ready;
  // Issue only when the output register is free or is being drained now,
  // which keeps the presented result stable under backpressure.
  assign w_issue    = !w_empty && (!r_out_valid || out_ready);

  assign in_ready   = w_in_ready;
  assign alu_en     = w_issue;
  assign alu_a      = w_empty ? 4'd0 : r_mem_a[r_rd_ptr];
  assign alu_b      = w_empty ? 4'd0 : r_mem_b[r_rd_ptr];
  assign alu_op     = w_empty ? 3'd0 : r_mem_op[r_rd_ptr];

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_op     = r_out_op;
  assign out_tag    = r_out_tag;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= in_a;
      r_mem_b[r_wr_ptr]   <= in_b;
      r_mem_op[r_wr_ptr]  <= in_op;
      r_mem_tag[r_wr_ptr] <= r_tag_cnt;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tag_cnt <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + LP_PTR_ONE;
        r_tag_cnt <= r_tag_cnt + 3'd1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register: load on issue, otherwise clear valid once consumed.
  // Data fields are left untouched when valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 8'h00;
      r_out_op     <= 3'b000;
      r_out_tag    <= 3'b000;
    end else if (w_issue) begin
      r_out_valid  <= 1'b1;
      r_out_result <= alu_result;
      r_out_op     <= r_mem_op[r_rd_ptr];
      r_out_tag    <= r_mem_tag[r_rd_ptr];
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_4bit_issue.sv
module tb_alu_4bit_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic       alu_en;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [2:0] out_op;
  logic [2:0] out_tag;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [2:0] op;
    logic [2:0] tag;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [7:0] res;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [2:0] exp_tag;
  vec_t       vecs[14];

  always #5 clk = ~clk;

  alu_4bit_issue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_en     (alu_en),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_tag    (out_tag),
    .count      (count)
  );

  // Stand-in for the downstream combinational alu_4bit.
  logic [7:0] sa, sb8;
  always_comb begin
    sa         = {{4{alu_a[3]}}, alu_a};
    sb8        = {{4{alu_b[3]}}, alu_b};
    alu_result = 8'h00;
    if (alu_en) begin
      case (alu_op)
        3'b000:  alu_result = sa + sb8;
        3'b001:  alu_result = sa - sb8;
        3'b010:  alu_result = sa + 8'd1;
        3'b011:  alu_result = sa - 8'd1;
        3'b100:  alu_result = (alu_a == 4'd0) ? 8'd1 : 8'd0;
        3'b101:  alu_result = ~sa;
        3'b110:  alu_result = sa | sb8;
        default: alu_result = sa & sb8;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {24'd0, out_result}, 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", {24'd0, out_result}, {24'd0, mon_e.r});
        check("out_op",     {29'd0, out_op},     {29'd0, mon_e.op});
        check("out_tag",    {29'd0, out_tag},    {29'd0, mon_e.tag});
      end
    end
  end

  task automatic push(input int idx);
    exp_t e;
    int   n;
    in_a     = vecs[idx].a;
    in_b     = vecs[idx].b;
    in_op    = vecs[idx].op;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    check("push_accept", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      e.r   = vecs[idx].res;
      e.op  = vecs[idx].op;
      e.tag = exp_tag;
      sb.push_back(e);
      exp_tag = exp_tag + 3'd1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
  endtask

  initial begin
    logic [2:0] tag_bp;
    vecs[0]  = '{4'h3, 4'h2, 3'b000, 8'h05};
    vecs[1]  = '{4'h2, 4'h5, 3'b001, 8'hFD};
    vecs[2]  = '{4'h7, 4'h0, 3'b010, 8'h08};
    vecs[3]  = '{4'h5, 4'hA, 3'b110, 8'hFF};
    vecs[4]  = '{4'hC, 4'h6, 3'b111, 8'h04};
    vecs[5]  = '{4'h1, 4'h1, 3'b000, 8'h02};
    vecs[6]  = '{4'h0, 4'h1, 3'b001, 8'hFF};
    vecs[7]  = '{4'h0, 4'h0, 3'b011, 8'hFF};
    vecs[8]  = '{4'h0, 4'h0, 3'b100, 8'h01};
    vecs[9]  = '{4'h5, 4'h0, 3'b101, 8'hFA};
    vecs[10] = '{4'h7, 4'h7, 3'b000, 8'h0E};
    vecs[11] = '{4'h8, 4'h8, 3'b000, 8'hF0};
    vecs[12] = '{4'h3, 4'h0, 3'b100, 8'h00};
    vecs[13] = '{4'h8, 4'h0, 3'b011, 8'hF7};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_op     = 3'd0;
    out_ready = 1'b1;
    exp_tag   = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",     {29'd0, count},      32'd0);
    check("rst_out_valid", {31'd0, out_valid},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},   32'd1);
    check("rst_alu_en",    {31'd0, alu_en},     32'd0);
    check("rst_out_result",{24'd0, out_result}, 32'd0);
    check("rst_alu_a",     {28'd0, alu_a},      32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: head reaches the ALU one edge after acceptance.
    push(0);
    check("single_alu_en",    {31'd0, alu_en},    32'd1);
    check("single_alu_a",     {28'd0, alu_a},     32'd3);
    check("single_alu_b",     {28'd0, alu_b},     32'd2);
    check("single_pre_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("single_alu_en_off", {31'd0, alu_en},     32'd0);
    check("single_valid",      {31'd0, out_valid},  32'd1);
    check("single_result",     {24'd0, out_result}, 32'h05);
    check("single_tag",        {29'd0, out_tag},    32'd0);
    wait_drain();

    // Stream of four back-to-back requests.
    for (int i = 1; i <= 4; i++) push(i);
    wait_drain();

    // Backpressure: five requests, first held in the output register.
    out_ready = 1'b0;
    tag_bp = exp_tag;
    for (int i = 5; i <= 9; i++) push(i);
    for (int k = 0; k < 3; k++) begin
      check("bp_count",    {29'd0, count},      32'd4);
      check("bp_in_ready", {31'd0, in_ready},   32'd0);
      check("bp_alu_en",   {31'd0, alu_en},     32'd0);
      check("bp_result",   {24'd0, out_result}, 32'h02);
      check("bp_tag",      {29'd0, out_tag},    {29'd0, tag_bp});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Refill a full FIFO while it drains.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) begin
        check("full_count",    {29'd0, count},    32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
      end
      push((10 + i) % 14);
    end
    wait_drain();

    // Asynchronous reset with queued work and a held result.
    out_ready = 1'b0;
    for (int i = 0; i <= 3; i++) push(i);
    check("prerst_valid", {31'd0, out_valid}, 32'd1);
    check("prerst_count", {29'd0, count},     32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid",    {31'd0, out_valid}, 32'd0);
    check("midrst_count",    {29'd0, count},     32'd0);
    check("midrst_alu_en",   {31'd0, alu_en},    32'd0);
    check("midrst_in_ready", {31'd0, in_ready},  32'd1);
    check("midrst_tag",      {29'd0, out_tag},   32'd0);
    sb.delete();
    exp_tag = 3'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Tag wrap: ten requests starting from tag 0.
    for (int i = 0; i <= 9; i++) push(i);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
